// File: rtl/multicycle_control.sv
// multicycle_control
// Moore control FSM for the multi-cycle MIPS core. It sequences one shared
// memory, one ALU and the IR/MDR/A/B/ALUOut registers in the datapath.
// The opcode is decoded in DECODE, and the FSM stalls in the memory states
// until mem_ready is high.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   opcode            IR[31:26], held stable by the datapath
//   mem_ready         memory finishes the current access this cycle
//   pcwrite .. pcsrc  datapath enables and mux selects
//   illegal_op        one-cycle pulse in DECODE on an unsupported opcode
//   state_dbg         current state encoding
//   cycle_cnt         cycles since reset release
//   instret_cnt       retired instructions
//
// Optional feature: define MC_PERF_CNT_EN to build the performance counters.
// When it is undefined, cycle_cnt and instret_cnt are tied to zero.
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pcwrite,
   output logic             pcwritecond,
   output logic             iord,
   output logic             memread,
   output logic             memwrite,
   output logic             irwrite,
   output logic             memtoreg,
   output logic             regdst,
   output logic             regwrite,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       aluop,
   output logic [1:0]       pcsrc,
   output logic             illegal_op,
   output logic [3:0]       state_dbg,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_ADDIEX = 4'd11,
      S_ADDIWB = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   state_t state_q, state_d;

   // Next-state logic. Memory states hold until mem_ready is high.
   // Unknown opcodes are skipped back to FETCH; PC has already advanced.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_LW)      state_d = S_MEMRD;
            else if (opcode == OP_SW) state_d = S_MEMWR;
            else                      state_d = S_FETCH;
         end
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_RWB;
         S_RWB:    state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // Moore outputs. FETCH is the only state that also looks at mem_ready,
   // so that PC and IR load only on the cycle the fetch completes.
   always_comb begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'd0;
      aluop       = 2'd0;
      pcsrc       = 2'd0;
      illegal_op  = 1'b0;
      case (state_q)
         S_FETCH: begin
            memread = 1'b1;
            alusrcb = 2'd1;
            pcwrite = mem_ready;
            irwrite = mem_ready;
         end
         S_DECODE: begin
            alusrcb    = 2'd3;
            illegal_op = !(opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI});
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'd2;
         end
         S_MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = 2'd2;
         end
         S_RWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         S_BRANCH: begin
            alusrca     = 1'b1;
            aluop       = 2'd1;
            pcwritecond = 1'b1;
            pcsrc       = 2'd1;
         end
         S_JUMP: begin
            pcwrite = 1'b1;
            pcsrc   = 2'd2;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'd2;
         end
         S_ADDIWB: begin
            regwrite = 1'b1;
         end
         default: ;
      endcase
   end

   assign state_dbg = state_q;

   // The state register. Reset aborts any instruction in flight, because
   // all outputs are decoded from this register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

`ifdef MC_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
   logic             retire;

   // An instruction retires when FETCH is re-entered from one of the final
   // states. An illegal opcode returns from DECODE and is not counted.
   always_comb begin
      retire        = (state_d == S_FETCH) &&
                      (state_q inside {S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB});
      cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
      instret_cnt_d = retire ? instret_cnt_q + CNT_W'(1) : instret_cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         cycle_cnt_q   <= cycle_cnt_d;
         instret_cnt_q <= instret_cnt_d;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
`else
   assign cycle_cnt   = {CNT_W{1'b0}};
   assign instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Bench for multicycle_control. A program is described as a list of
// instructions, each with its own fetch and memory wait counts. The bench
// expands that list into the per-cycle state walk the control unit should
// take, then compares state, every control output and the counters on
// each cycle. The same macro, MC_PERF_CNT_EN, selects the counter
// expectations.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
   logic        memtoreg, regdst, regwrite, alusrca, illegal_op;
   logic [1:0]  alusrcb, aluop, pcsrc;
   logic [3:0]  state_dbg;
   logic [31:0] cycle_cnt, instret_cnt;

   int checks = 0;
   int errors = 0;

   localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3;
   localparam int ST_MEMRD = 4, ST_MEMWB = 5, ST_MEMWR = 6, ST_EXEC = 7;
   localparam int ST_RWB = 8, ST_BRANCH = 9, ST_JUMP = 10, ST_ADDIEX = 11, ST_ADDIWB = 12;

   // Program description: opcode, fetch wait cycles, memory wait cycles.
   int q_op[$];
   int q_fw[$];
   int q_mw[$];

   // Expected per-cycle walk, starting with the first FETCH after reset.
   int         e_state[$];
   bit         e_ready[$];
   logic [5:0] e_opc[$];
   int         e_inst[$];

   multicycle_control #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
      .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
      .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
      .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
      .illegal_op(illegal_op), .state_dbg(state_dbg),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   wire [16:0] dut_vec = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                          memtoreg, regdst, regwrite, alusrca, alusrcb, aluop,
                          pcsrc, illegal_op};

   function automatic bit is_legal(int op);
      return (op == 35 || op == 43 || op == 0 || op == 4 || op == 2 || op == 8);
   endfunction

   // Control word each state should produce, taken from the state table.
   function automatic logic [16:0] exp_out(int st, bit rdy, int op);
      logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, ill;
      logic [1:0] asb, aop, ps;
      {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
      asb = 2'd0; aop = 2'd0; ps = 2'd0;
      case (st)
         ST_FETCH:  begin mr = 1; asb = 2'd1; pw = rdy; irw = rdy; end
         ST_DECODE: begin asb = 2'd3; ill = !is_legal(op); end
         ST_MEMADR: begin asa = 1; asb = 2'd2; end
         ST_MEMRD:  begin mr = 1; io = 1; end
         ST_MEMWB:  begin rw = 1; m2r = 1; end
         ST_MEMWR:  begin mw = 1; io = 1; end
         ST_EXEC:   begin asa = 1; aop = 2'd2; end
         ST_RWB:    begin rw = 1; rd = 1; end
         ST_BRANCH: begin asa = 1; aop = 2'd1; pwc = 1; ps = 2'd1; end
         ST_JUMP:   begin pw = 1; ps = 2'd2; end
         ST_ADDIEX: begin asa = 1; asb = 2'd2; end
         ST_ADDIWB: begin rw = 1; end
         default: ;
      endcase
      return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, ill};
   endfunction

   function automatic void push_e(int s, bit r, int o, int n);
      e_state.push_back(s);
      e_ready.push_back(r);
      e_opc.push_back(6'(o));
      e_inst.push_back(n);
   endfunction

   // Expands the program into cycles. In states that ignore the memory
   // handshake, mem_ready is random to show it has no effect there.
   function automatic void build_expected();
      int done = 0;
      e_state.delete(); e_ready.delete(); e_opc.delete(); e_inst.delete();
      foreach (q_op[k]) begin
         int op = q_op[k];
         for (int w = 0; w < q_fw[k]; w++) push_e(ST_FETCH, 1'b0, op, done);
         push_e(ST_FETCH, 1'b1, op, done);
         push_e(ST_DECODE, 1'($urandom), op, done);
         case (op)
            35: begin
               push_e(ST_MEMADR, 1'($urandom), op, done);
               for (int w = 0; w < q_mw[k]; w++) push_e(ST_MEMRD, 1'b0, op, done);
               push_e(ST_MEMRD, 1'b1, op, done);
               push_e(ST_MEMWB, 1'($urandom), op, done);
            end
            43: begin
               push_e(ST_MEMADR, 1'($urandom), op, done);
               for (int w = 0; w < q_mw[k]; w++) push_e(ST_MEMWR, 1'b0, op, done);
               push_e(ST_MEMWR, 1'b1, op, done);
            end
            0: begin
               push_e(ST_EXEC, 1'($urandom), op, done);
               push_e(ST_RWB, 1'($urandom), op, done);
            end
            4: push_e(ST_BRANCH, 1'($urandom), op, done);
            2: push_e(ST_JUMP, 1'($urandom), op, done);
            8: begin
               push_e(ST_ADDIEX, 1'($urandom), op, done);
               push_e(ST_ADDIWB, 1'($urandom), op, done);
            end
            default: ;
         endcase
         if (is_legal(op)) done++;
      end
      // A trailing stalled FETCH shows the last instruction retired.
      push_e(ST_FETCH, 1'b0, 0, done);
   endfunction

   function automatic void set_prog1(int op, int fw, int mw);
      q_op.delete(); q_fw.delete(); q_mw.delete();
      q_op.push_back(op); q_fw.push_back(fw); q_mw.push_back(mw);
   endfunction

   // Asserts reset with mem_ready high, checks everything is zero, then
   // releases it at a falling edge and checks IDLE.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'b1; opcode = 6'd35;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (dut_vec !== 17'd0 || state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: got vec=%h state=%0d required vec=0 state=0", dut_vec, state_dbg);
         end
         checks++;
         if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got cyc=%0d ins=%0d required 0 0", cycle_cnt, instret_cnt);
         end
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (state_dbg !== 4'd0 || dut_vec !== 17'd0) begin
         errors++;
         $display("FAIL reset_release_idle: got state=%0d vec=%h required state=0 vec=0", state_dbg, dut_vec);
      end
   endtask

   // Steps through the expected walk one cycle at a time.
   task automatic run_expected(input int max_steps);
      int exp_cyc, exp_ins;
      for (int i = 0; i < e_state.size() && i < max_steps; i++) begin
         @(negedge clk);
         opcode = e_opc[i];
         mem_ready = e_ready[i];
         #1;
`ifdef MC_PERF_CNT_EN
         exp_cyc = i + 1;
         exp_ins = e_inst[i];
`else
         exp_cyc = 0;
         exp_ins = 0;
`endif
         checks++;
         if (state_dbg !== 4'(e_state[i])) begin
            errors++;
            $display("FAIL state step %0d: got %0d required %0d", i, state_dbg, e_state[i]);
         end
         checks++;
         if (dut_vec !== exp_out(e_state[i], e_ready[i], int'(e_opc[i]))) begin
            errors++;
            $display("FAIL controls step %0d state %0d: got %h required %h", i, e_state[i],
                     dut_vec, exp_out(e_state[i], e_ready[i], int'(e_opc[i])));
         end
         checks++;
         if (cycle_cnt !== 32'(exp_cyc) || instret_cnt !== 32'(exp_ins)) begin
            errors++;
            $display("FAIL counters step %0d: got cyc=%0d ins=%0d required cyc=%0d ins=%0d",
                     i, cycle_cnt, instret_cnt, exp_cyc, exp_ins);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_lw();
      do_reset();
      set_prog1(35, 0, 0);
      build_expected();
      run_expected(1000);
   endtask

   task automatic test_sw_wait();
      do_reset();
      set_prog1(43, 0, 3);
      build_expected();
      run_expected(1000);
   endtask

   task automatic test_fetch_stall();
      do_reset();
      set_prog1(0, 2, 0);
      build_expected();
      run_expected(1000);
   endtask

   task automatic test_back_to_back();
      do_reset();
      q_op = '{0, 4, 2, 8};
      q_fw = '{0, 0, 0, 0};
      q_mw = '{0, 0, 0, 0};
      build_expected();
      run_expected(1000);
   endtask

   task automatic test_illegal();
      do_reset();
      q_op = '{63, 35, 17, 43};
      q_fw = '{0, 0, 1, 0};
      q_mw = '{0, 1, 0, 0};
      build_expected();
      run_expected(1000);
   endtask

   task automatic test_random();
      int ops[6] = '{35, 43, 0, 4, 2, 8};
      do_reset();
      q_op.delete(); q_fw.delete(); q_mw.delete();
      for (int k = 0; k < 40; k++) begin
         int op;
         if ($urandom_range(0, 7) == 0) begin
            op = int'($urandom_range(0, 63));
            while (is_legal(op)) op = int'($urandom_range(0, 63));
         end else begin
            op = ops[$urandom_range(0, 5)];
         end
         q_op.push_back(op);
         q_fw.push_back(int'($urandom_range(0, 2)));
         q_mw.push_back(int'($urandom_range(0, 2)));
      end
      build_expected();
      run_expected(100000);
   endtask

   // Walks into MEMWR with the memory stalled, then drops reset between
   // clock edges: memwrite must fall at once and the FSM restart in IDLE.
   task automatic test_reset_mid();
      do_reset();
      set_prog1(43, 0, 6);
      build_expected();
      run_expected(5);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (memwrite !== 1'b0 || regwrite !== 1'b0 || state_dbg !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid_abort: got memwrite=%b regwrite=%b state=%0d required 0 0 0",
                  memwrite, regwrite, state_dbg);
      end
      @(negedge clk);
      mem_ready = 1'b1;
      rst = 1'b1;
      #1;
      checks++;
      if (state_dbg !== 4'd0 || dut_vec !== 17'd0) begin
         errors++;
         $display("FAIL reset_mid_idle: got state=%0d vec=%h required state=0 vec=0", state_dbg, dut_vec);
      end
      @(negedge clk);
      #1;
      checks++;
      if (state_dbg !== 4'd1 || memwrite !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_fetch: got state=%0d memwrite=%b required state=1 memwrite=0",
                  state_dbg, memwrite);
      end
   endtask

   initial begin
      rst = 1'b1;
      opcode = 6'd0;
      mem_ready = 1'b0;
      test_reset();
      test_lw();
      test_sw_wait();
      test_fetch_stall();
      test_back_to_back();
      test_illegal();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
